debounce_scan_ctrl: RTL and testbench
=====================================

# debounce_scan_ctrl

Time-multiplexed debounce controller for the pulse-counter front end. It scans N_CH raw button inputs round-robin, one channel per sample tick, and keeps a per-channel shift-register history. Each channel gets a debounced level. Each debounced press (0→1) is queued as an event and delivered to the counter through a valid/ready handshake with round-robin arbitration.

## Interface
- N_CH, 4: number of button channels (≥2).
- DIV, 50000: clock cycles per sample tick (≥2).
- HIST, 8: history depth in samples (≥2).
- CW, derived: max(1, clog2(N_CH)).

- Clk  in  1  system clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- Btn_IN  in  N_CH  raw, undebounced button inputs (pre-synchronised).
- Level_OUT  out  N_CH  debounced level per channel.
- Tick_OUT  out  1  one-cycle sample strobe.
- Evt_Valid  out  1  press event present.
- Evt_Ch  out  CW  channel index of the presented event.
- Evt_Ready  in  1  consumer accepts the event.
- Overrun_OUT  out  1  one-cycle pulse: press lost on an already-pending channel.

## Operation
- Reset values:
  - div_cnt=0, ch_ptr=0, rr_ptr=0.
  - All hist=0, Level_OUT=0, pending=0.
  - Evt_Valid=0, Evt_Ch=0, Overrun_OUT=0, Tick_OUT=0.
  - Scan FSM=IDLE, event FSM=EMPTY.
  - Reset mid-handshake drops the presented event and all pending events.
- Prescaler:
  - div_cnt counts 0..DIV-1 and wraps to 0.
  - Tick_OUT=1 exactly in cycles where div_cnt==DIV-1.
- Scan FSM (IDLE, EVAL):
  - IDLE on tick: hist[ch_ptr] <= {hist[ch_ptr][HIST-2:0], Btn_IN[ch_ptr]}, then go to EVAL.
  - EVAL, for channel ch_ptr:
    - hist all ones and Level=0 → Level<=1 and set pending[ch_ptr] (press).
    - hist all zeros and Level=1 → Level<=0 (release; no event).
    - Otherwise Level holds (hysteresis).
    - Then ch_ptr <= (ch_ptr+1) mod N_CH and go to IDLE.
  - DIV≥2 guarantees EVAL finishes before the next tick.
- Event FSM (EMPTY, PRESENT):
  - EMPTY with pending≠0:
    - Select the first set pending bit searching upward from rr_ptr, modulo N_CH.
    - Evt_Ch<=sel, Evt_Valid<=1, pending[sel]<=0, rr_ptr<=(sel+1) mod N_CH.
    - Go to PRESENT.
  - PRESENT: Evt_Valid and Evt_Ch stay stable until Evt_Valid&Evt_Ready. On transfer, Evt_Valid<=0 and go to EMPTY.
  - Evt_Ready is ignored while Evt_Valid=0.
  - Maximum throughput is one event per 2 cycles (mandatory bubble cycle).
- Simultaneous events:
  - EVAL sets pending[c] while pending[c] is already 1: Overrun_OUT=1 for one cycle; pending stays 1 (events merge).
  - EVAL sets pending[c] on the same edge the arbiter clears it by loading c: set wins, pending[c]=1, no overrun.
  - The channel held in the Evt register does not count as pending for overrun.

## Timing
- Cycle 0 is the first cycle with Rst=0.
- Tick k occurs in cycle k·DIV + DIV-1.
- Channel c is sampled on ticks k ≡ c (mod N_CH).
- The sample is taken at the edge ending the tick cycle T.
- Level_OUT and pending change at the edge ending T+1, visible in T+2.
- Evt_Valid rises in T+3 when the event FSM was EMPTY.
- Minimum press-to-Level latency: (HIST-1)·N_CH·DIV + 2 cycles after the first qualifying sample tick.

## Test plan
All scenarios use N_CH=4, DIV=4, HIST=8.
1. Reset and prescaler: hold Rst 3 cycles, release → all outputs 0. Tick_OUT high in cycles 3, 7, 11, … and never in two consecutive cycles.
2. Single press: Btn_IN=4'b0001 from cycle 0, Evt_Ready=1 → Level_OUT[0]=1 at cycle 117. Evt_Valid=1 with Evt_Ch=0 at cycle 118; Evt_Valid=0 at cycle 119. No further events while held.
3. Bounce rejection: channel 1 sampled 1,1,1,1,1,1,1,0 repeating → Level_OUT[1] stays 0 and no event. Then hold 1 for 8 channel-1 samples → Level_OUT[1]=1 and one event, Evt_Ch=1.
4. Round-robin: Evt_Ready=0, press all four channels. Ch0 is presented first and ch1–3 become pending. Raise Evt_Ready=1 → order 0,1,2,3 with one idle cycle between events. Next arbitration starts from rr_ptr=0.
5. Overrun: Evt_Ready=0, press/release ch2 three times (8 samples each phase). First press presented, second pending, third press → Overrun_OUT pulses once. After Evt_Ready=1, exactly two events with Evt_Ch=2.
6. Reset mid-operation: Evt_Valid=1 with two pending, assert Rst for 1 cycle. Next cycle Evt_Valid=0, Level_OUT=0, pending empty, Tick_OUT restarts at cycle 3 after release.

Source files
------------

// File: rtl/debounce_scan_ctrl.sv
// Purpose: round-robin scanned shift-register debouncer with press-event queue and valid/ready delivery.
// Latency: level change 2 cycles after the qualifying sample edge; Evt_Valid one cycle after that when idle.
// Backpressure: Evt_Ready low holds the presented event; later presses wait in a per-channel pending bit,
//               a repeated press on a pending channel merges and pulses Overrun_OUT.
//
// Ports:
//   Clk, Rst      clock and synchronous active-high reset
//   Btn_IN        raw (pre-synchronised) button levels, one bit per channel
//   Level_OUT     debounced level per channel
//   Tick_OUT      one-cycle sample strobe (every DIV cycles)
//   Evt_Valid/Evt_Ch/Evt_Ready  press event handshake, Evt_Ch = channel index
//   Overrun_OUT   one-cycle pulse when a press is merged into an already pending one
module debounce_scan_ctrl #(
  parameter int N_CH = 4,
  parameter int DIV  = 50000,
  parameter int HIST = 8,
  localparam int CW  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [N_CH-1:0] Btn_IN,
  output logic [N_CH-1:0] Level_OUT,
  output logic            Tick_OUT,
  output logic            Evt_Valid,
  output logic [CW-1:0]   Evt_Ch,
  input  logic            Evt_Ready,
  output logic            Overrun_OUT
);

  localparam int DW = $clog2(DIV);

  typedef enum logic {S_IDLE, S_EVAL} scan_state_t;
  typedef enum logic {E_EMPTY, E_PRESENT} evt_state_t;

  // (a + b) mod N_CH for small b
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N_CH) s = s - N_CH;
    return CW'(s);
  endfunction

  // ---------------- prescaler ----------------
  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick     = (div_cnt == DW'(DIV - 1));
  assign Tick_OUT = tick;

  always_ff @(posedge Clk) begin
    if (Rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // ---------------- scan FSM ----------------
  scan_state_t     scan_q, scan_d;
  logic            do_sample, do_eval;
  logic [CW-1:0]   ch_ptr;
  logic [HIST-1:0] hist [N_CH];
  logic [N_CH-1:0] level_q;
  logic [HIST-1:0] cur_hist;
  logic            press, release_c;

  always_ff @(posedge Clk) begin
    if (Rst) scan_q <= S_IDLE;
    else     scan_q <= scan_d;
  end

  always_comb begin
    scan_d = scan_q;
    case (scan_q)
      S_IDLE:  if (tick) scan_d = S_EVAL;
      S_EVAL:  scan_d = S_IDLE;
      default: scan_d = S_IDLE;
    endcase
  end

  always_comb begin
    do_sample = (scan_q == S_IDLE) && tick;
    do_eval   = (scan_q == S_EVAL);
  end

  // EVAL looks at the history that already includes the sample just shifted in
  assign cur_hist  = hist[ch_ptr];
  assign press     = do_eval && (&cur_hist) && !level_q[ch_ptr];
  assign release_c = do_eval && !(|cur_hist) && level_q[ch_ptr];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < N_CH; i++) hist[i] <= '0;
    end else if (do_sample) begin
      hist[ch_ptr] <= {hist[ch_ptr][HIST-2:0], Btn_IN[ch_ptr]};
    end
  end

  // mixed histories leave the level untouched (hysteresis)
  always_ff @(posedge Clk) begin
    if (Rst)            level_q <= '0;
    else if (press)     level_q[ch_ptr] <= 1'b1;
    else if (release_c) level_q[ch_ptr] <= 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Rst)          ch_ptr <= '0;
    else if (do_eval) ch_ptr <= wrap_add(ch_ptr, 1);
  end

  assign Level_OUT = level_q;

  // ---------------- event FSM + arbiter ----------------
  evt_state_t      evt_q, evt_d;
  logic [N_CH-1:0] pending, pend_clr, pending_d;
  logic [CW-1:0]   rr_ptr, arb_sel;
  logic            arb_found, arb_load, overrun_d;

  always_ff @(posedge Clk) begin
    if (Rst) evt_q <= E_EMPTY;
    else     evt_q <= evt_d;
  end

  always_comb begin
    evt_d = evt_q;
    case (evt_q)
      E_EMPTY:   if (|pending) evt_d = E_PRESENT;
      E_PRESENT: if (Evt_Ready) evt_d = E_EMPTY;
      default:   evt_d = E_EMPTY;
    endcase
  end

  always_comb begin
    Evt_Valid = (evt_q == E_PRESENT);
    arb_load  = (evt_q == E_EMPTY) && (|pending);
  end

  // first set pending bit at or above rr_ptr, wrapping
  always_comb begin
    arb_sel   = '0;
    arb_found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!arb_found && pending[wrap_add(rr_ptr, i)]) begin
        arb_sel   = wrap_add(rr_ptr, i);
        arb_found = 1'b1;
      end
    end
  end

  // a new press beats the arbiter's clear of the same bit; only a bit still
  // set after the clear counts as an overrun
  always_comb begin
    pend_clr = pending;
    if (arb_load) pend_clr[arb_sel] = 1'b0;
    pending_d = pend_clr;
    if (press) pending_d[ch_ptr] = 1'b1;
    overrun_d = press && pend_clr[ch_ptr];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pending     <= '0;
      Overrun_OUT <= 1'b0;
      Evt_Ch      <= '0;
      rr_ptr      <= '0;
    end else begin
      pending     <= pending_d;
      Overrun_OUT <= overrun_d;
      if (arb_load) begin
        Evt_Ch <= arb_sel;
        rr_ptr <= wrap_add(arb_sel, 1);
      end
    end
  end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
module tb_debounce_scan_ctrl;
  localparam int N_CH = 4;
  localparam int DIV  = 4;
  localparam int HIST = 8;
  localparam int CW   = 2;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [N_CH-1:0] Btn_IN;
  logic [N_CH-1:0] Level_OUT;
  logic            Tick_OUT;
  logic            Evt_Valid;
  logic [CW-1:0]   Evt_Ch;
  logic            Evt_Ready;
  logic            Overrun_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  debounce_scan_ctrl #(.N_CH(N_CH), .DIV(DIV), .HIST(HIST)) dut (
    .Clk(Clk), .Rst(Rst), .Btn_IN(Btn_IN), .Level_OUT(Level_OUT),
    .Tick_OUT(Tick_OUT), .Evt_Valid(Evt_Valid), .Evt_Ch(Evt_Ch),
    .Evt_Ready(Evt_Ready), .Overrun_OUT(Overrun_OUT)
  );

  // ---------------- reference model ----------------
  // Each channel's history is summarised as the value and length of its most
  // recent run of identical samples; "last HIST samples all equal v" is then
  // simply run_val==v && run_len>=HIST.
  int cyc;          // cycles since the last reset edge
  int m_ticks;      // sample ticks taken since reset
  int eval_ch;      // channel sampled on the previous edge, -1 if none
  int run_val [N_CH];
  int run_len [N_CH];
  bit m_level [N_CH];
  bit m_pend  [N_CH];
  bit m_valid;
  int m_ch;
  int m_rr;
  bit m_ovr;

  task automatic model_reset();
    cyc = 0; m_ticks = 0; eval_ch = -1;
    for (int c = 0; c < N_CH; c++) begin
      run_val[c] = 0; run_len[c] = HIST; m_level[c] = 0; m_pend[c] = 0;
    end
    m_valid = 0; m_ch = 0; m_rr = 0; m_ovr = 0;
  endtask

  function automatic logic [N_CH-1:0] m_level_vec();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = m_level[c];
    return v;
  endfunction

  function automatic bit m_tick();
    return (cyc % DIV) == (DIV - 1);
  endfunction

  // advance the model across one clock edge using the inputs of the ending cycle
  task automatic model_edge();
    int press_c;
    if (Rst) begin
      model_reset();
      return;
    end
    press_c = -1;
    m_ovr   = 0;
    if (eval_ch >= 0) begin
      if (run_val[eval_ch] == 1 && run_len[eval_ch] >= HIST && !m_level[eval_ch]) begin
        m_level[eval_ch] = 1;
        press_c = eval_ch;
      end else if (run_val[eval_ch] == 0 && run_len[eval_ch] >= HIST && m_level[eval_ch]) begin
        m_level[eval_ch] = 0;
      end
    end
    if (m_valid) begin
      if (Evt_Ready) m_valid = 0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        int c;
        c = (m_rr + i) % N_CH;
        if (m_pend[c]) begin
          m_valid = 1; m_ch = c; m_pend[c] = 0; m_rr = (c + 1) % N_CH;
          break;
        end
      end
    end
    if (press_c >= 0) begin
      if (m_pend[press_c]) m_ovr = 1;
      m_pend[press_c] = 1;
    end
    eval_ch = -1;
    if (m_tick()) begin
      int c, s;
      c = m_ticks % N_CH;
      s = int'(Btn_IN[c]);
      if (s == run_val[c]) begin
        if (run_len[c] < HIST) run_len[c]++;
      end else begin
        run_val[c] = s; run_len[c] = 1;
      end
      eval_ch = c;
      m_ticks++;
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input int n);
    Rst = 1'b1;
    repeat (n) step();
    Rst = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // number of samples already taken on channel c
  function automatic int samples_of(input int c);
    return (m_ticks + N_CH - 1 - c) / N_CH;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    Btn_IN = '0; Evt_Ready = 1'b0;
    do_reset(3);
    n_cmp++; if (Level_OUT !== '0) begin n_bad++; $display("FAIL reset_level: got %b expected 0", Level_OUT); end
    n_cmp++; if (Evt_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", Evt_Valid); end
    n_cmp++; if (Evt_Ch !== '0) begin n_bad++; $display("FAIL reset_ch: got %0d expected 0", Evt_Ch); end
    n_cmp++; if (Overrun_OUT !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", Overrun_OUT); end
    n_cmp++; if (Tick_OUT !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b expected 0", Tick_OUT); end
  endtask

  task automatic test_prescaler();
    logic prev;
    prev = 1'b0;
    for (int i = 0; i < 24; i++) begin
      n_cmp++;
      if (Tick_OUT !== ((cyc % DIV) == DIV - 1)) begin
        n_bad++; $display("FAIL tick_cycle_%0d: got %b expected %b", cyc, Tick_OUT, (cyc % DIV) == DIV - 1);
      end
      n_cmp++;
      if (prev && Tick_OUT) begin n_bad++; $display("FAIL tick_back_to_back: got 1 in cycle %0d expected 0", cyc); end
      prev = Tick_OUT;
      step();
    end
  endtask

  task automatic test_single_press();
    int n_evt;
    do_reset(3);
    Btn_IN = 4'b0001; Evt_Ready = 1'b1; n_evt = 0;
    while (cyc < 400) begin
      if (cyc == 116) begin
        n_cmp++; if (Level_OUT[0] !== 1'b0) begin n_bad++; $display("FAIL press_level_early: got %b expected 0", Level_OUT[0]); end
      end
      if (cyc == 117) begin
        n_cmp++; if (Level_OUT[0] !== 1'b1) begin n_bad++; $display("FAIL press_level_117: got %b expected 1", Level_OUT[0]); end
        n_cmp++; if (Evt_Valid !== 1'b0) begin n_bad++; $display("FAIL press_valid_117: got %b expected 0", Evt_Valid); end
      end
      if (cyc == 118) begin
        n_cmp++; if (Evt_Valid !== 1'b1) begin n_bad++; $display("FAIL press_valid_118: got %b expected 1", Evt_Valid); end
        n_cmp++; if (Evt_Ch !== 2'd0) begin n_bad++; $display("FAIL press_ch_118: got %0d expected 0", Evt_Ch); end
      end
      if (cyc == 119) begin
        n_cmp++; if (Evt_Valid !== 1'b0) begin n_bad++; $display("FAIL press_valid_119: got %b expected 0", Evt_Valid); end
      end
      if (Evt_Valid && Evt_Ready) n_evt++;
      step();
    end
    n_cmp++; if (n_evt !== 1) begin n_bad++; $display("FAIL press_event_count: got %0d expected 1", n_evt); end
    n_cmp++; if (Level_OUT !== m_level_vec()) begin n_bad++; $display("FAIL press_level_hold: got %b expected %b", Level_OUT, m_level_vec()); end
  endtask

  task automatic test_bounce();
    int n_evt, waited;
    bit lvl_seen, got;
    do_reset(3);
    Btn_IN = '0; Evt_Ready = 1'b1; n_evt = 0; lvl_seen = 0;
    for (int i = 0; i < 400; i++) begin
      Btn_IN[1] = (samples_of(1) % 8) != 7;
      if (Level_OUT[1]) lvl_seen = 1;
      if (Evt_Valid) n_evt++;
      step();
    end
    n_cmp++; if (lvl_seen !== 1'b0) begin n_bad++; $display("FAIL bounce_level: got 1 expected 0"); end
    n_cmp++; if (n_evt !== 0) begin n_bad++; $display("FAIL bounce_events: got %0d expected 0", n_evt); end
    Btn_IN[1] = 1'b1;
    waited = 0; got = 0;
    while (!got && waited < 300) begin
      if (Evt_Valid) got = 1;
      else begin step(); waited++; end
    end
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL bounce_press_timeout: got no event in 300 cycles expected one");
    end else begin
      n_cmp++; if (Evt_Ch !== 2'd1) begin n_bad++; $display("FAIL bounce_press_ch: got %0d expected 1", Evt_Ch); end
      n_cmp++; if (Level_OUT[1] !== 1'b1) begin n_bad++; $display("FAIL bounce_press_level: got %b expected 1", Level_OUT[1]); end
    end
    n_evt = 0;
    for (int i = 0; i < 60; i++) begin
      if (Evt_Valid) n_evt++;
      step();
    end
    n_cmp++; if (n_evt !== (got ? 1 : 0)) begin n_bad++; $display("FAIL bounce_single_event: got %0d valid cycles expected %0d", n_evt, got ? 1 : 0); end
  endtask

  task automatic test_round_robin();
    int chs[$];
    int cycs[$];
    do_reset(3);
    Evt_Ready = 1'b0; Btn_IN = 4'b1111;
    run_to(170);
    n_cmp++; if (Evt_Valid !== 1'b1) begin n_bad++; $display("FAIL rr_first_valid: got %b expected 1", Evt_Valid); end
    n_cmp++; if (Evt_Ch !== 2'd0) begin n_bad++; $display("FAIL rr_first_ch: got %0d expected 0", Evt_Ch); end
    n_cmp++; if (Level_OUT !== 4'b1111) begin n_bad++; $display("FAIL rr_levels: got %b expected 1111", Level_OUT); end
    Evt_Ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (Evt_Valid) begin chs.push_back(int'(Evt_Ch)); cycs.push_back(cyc); end
      step();
    end
    n_cmp++;
    if (chs.size() !== 4) begin
      n_bad++; $display("FAIL rr_count: got %0d events expected 4", chs.size());
    end else begin
      n_cmp++; if (cycs[0] !== 170) begin n_bad++; $display("FAIL rr_first_cycle: got %0d expected 170", cycs[0]); end
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (chs[i] !== i) begin n_bad++; $display("FAIL rr_order_%0d: got %0d expected %0d", i, chs[i], i); end
        if (i > 0) begin
          n_cmp++; if (cycs[i] - cycs[i-1] !== 2) begin n_bad++; $display("FAIL rr_gap_%0d: got %0d expected 2", i, cycs[i] - cycs[i-1]); end
        end
      end
    end
  endtask

  task automatic test_overrun();
    int n_ovr, n_evt, n2;
    bit bad_ch;
    do_reset(3);
    Evt_Ready = 1'b0; Btn_IN = '0; n_ovr = 0;
    for (int i = 0; i < 700; i++) begin
      n2 = samples_of(2);
      Btn_IN[2] = (n2 < 40) && ((n2 / 8) % 2 == 0);
      n_cmp++; if (Overrun_OUT !== m_ovr) begin n_bad++; $display("FAIL ovr_cycle_%0d: got %b expected %b", cyc, Overrun_OUT, m_ovr); end
      if (Overrun_OUT) n_ovr++;
      step();
    end
    n_cmp++; if (n_ovr !== 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d expected 1", n_ovr); end
    n_cmp++; if (Evt_Valid !== 1'b1 || Evt_Ch !== 2'd2) begin n_bad++; $display("FAIL ovr_presented: got valid=%b ch=%0d expected valid=1 ch=2", Evt_Valid, Evt_Ch); end
    Evt_Ready = 1'b1; n_evt = 0; bad_ch = 0;
    for (int i = 0; i < 30; i++) begin
      if (Evt_Valid) begin n_evt++; if (Evt_Ch !== 2'd2) bad_ch = 1; end
      step();
    end
    n_cmp++; if (n_evt !== 2) begin n_bad++; $display("FAIL ovr_event_count: got %0d expected 2", n_evt); end
    n_cmp++; if (bad_ch !== 1'b0) begin n_bad++; $display("FAIL ovr_event_ch: got a channel other than 2 expected only 2"); end
  endtask

  task automatic test_reset_mid();
    int first_tick, n_valid;
    do_reset(3);
    Evt_Ready = 1'b0; Btn_IN = 4'b1111;
    run_to(126);
    n_cmp++; if (Evt_Valid !== 1'b1) begin n_bad++; $display("FAIL mid_valid_before: got %b expected 1", Evt_Valid); end
    Rst = 1'b1; Btn_IN = '0;
    step();
    Rst = 1'b0;
    n_cmp++; if (Evt_Valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid_after: got %b expected 0", Evt_Valid); end
    n_cmp++; if (Level_OUT !== '0) begin n_bad++; $display("FAIL mid_level_after: got %b expected 0", Level_OUT); end
    n_cmp++; if (Overrun_OUT !== 1'b0) begin n_bad++; $display("FAIL mid_overrun_after: got %b expected 0", Overrun_OUT); end
    first_tick = -1; n_valid = 0;
    for (int i = 0; i < 30; i++) begin
      if (Tick_OUT && first_tick < 0) first_tick = cyc;
      if (Evt_Valid) n_valid++;
      step();
    end
    n_cmp++; if (first_tick !== 3) begin n_bad++; $display("FAIL mid_first_tick: got %0d expected 3", first_tick); end
    n_cmp++; if (n_valid !== 0) begin n_bad++; $display("FAIL mid_pending_flushed: got %0d valid cycles expected 0", n_valid); end
  endtask

  task automatic test_random();
    do_reset(3);
    Btn_IN = '0; Evt_Ready = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 399) == 0) Btn_IN[c] = ~Btn_IN[c];
      Evt_Ready = ($urandom_range(0, 3) == 0);
      n_cmp++; if (Tick_OUT !== m_tick()) begin n_bad++; $display("FAIL rnd_tick_%0d: got %b expected %b", cyc, Tick_OUT, m_tick()); end
      n_cmp++; if (Level_OUT !== m_level_vec()) begin n_bad++; $display("FAIL rnd_level_%0d: got %b expected %b", cyc, Level_OUT, m_level_vec()); end
      n_cmp++; if (Evt_Valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid_%0d: got %b expected %b", cyc, Evt_Valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (int'(Evt_Ch) !== m_ch) begin n_bad++; $display("FAIL rnd_ch_%0d: got %0d expected %0d", cyc, Evt_Ch, m_ch); end
      end
      n_cmp++; if (Overrun_OUT !== m_ovr) begin n_bad++; $display("FAIL rnd_overrun_%0d: got %b expected %b", cyc, Overrun_OUT, m_ovr); end
      step();
    end
  endtask

  initial begin
    Rst = 1'b1; Btn_IN = '0; Evt_Ready = 1'b0;
    model_reset();
    test_reset();
    test_prescaler();
    test_single_press();
    test_bounce();
    test_round_robin();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
